// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter for the shared FIFO write port
//
// Shares one FIFO write port among NREQ requesters. A requester is granted
// for up to MAX_BURST words; after every burst the block spends one IDLE
// cycle arbitrating, starting the search just past the previous grantee so
// every requester is eventually served.
//
// Ports:
//   wr_clk    FIFO write clock, rising edge
//   rst       asynchronous active-high reset
//   req       per-requester request
//   req_data  per-requester word, requester i in [i*DW +: DW]
//   ack       per-requester word-consumed strobe
//   full      FIFO full flag (write domain), used combinationally
//   wr_en     FIFO write enable
//   din       FIFO write data (0 when not writing)
//   grant_id  index of the current or most recent grant
//   busy      high while a burst is in progress

module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4,
  localparam int GW       = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int BW       = $clog2(MAX_BURST + 1)
) (
  input  logic                 wr_clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      ack,
  input  logic                 full,
  output logic                 wr_en,
  output logic [DW-1:0]        din,
  output logic [GW-1:0]        grant_id,
  output logic                 busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] gnt_q, gnt_d;
  logic [GW-1:0] ptr_q, ptr_d;
  logic [BW-1:0] cnt_q, cnt_d;

  logic          sel_found;
  logic [GW-1:0] sel_idx;
  logic          gnt_req;
  logic          accept;
  logic          last_word;

  // Modular add for requester indices; base < NREQ and k < NREQ, so a
  // single subtraction is enough to wrap.
  function automatic logic [GW-1:0] wrap_add(input logic [GW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return GW'(s);
  endfunction

  // Round-robin search: first requester with req high, starting at ptr_q
  // and wrapping. Only consulted in IDLE.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!sel_found && req[wrap_add(ptr_q, k)]) begin
        sel_found = 1'b1;
        sel_idx   = wrap_add(ptr_q, k);
      end
    end
  end

  // Burst datapath. full gates the write directly: the FIFO registers its
  // own flag, so a low full at this edge means the slot is really free.
  always_comb begin
    gnt_req   = req[gnt_q];
    accept    = (state_q == BURST) && gnt_req && !full;
    last_word = (cnt_q == BW'(MAX_BURST - 1));
    wr_en     = accept;
    ack       = '0;
    ack[gnt_q] = accept;
    din       = accept ? req_data[int'(gnt_q)*DW +: DW] : '0;
    busy      = (state_q == BURST);
    grant_id  = gnt_q;
  end

  // Next-state logic. A stall (full high with req held) changes nothing.
  // A dropped request ends the burst even mid-stall.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (sel_found) begin
          gnt_d   = sel_idx;
          cnt_d   = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        if (accept) cnt_d = cnt_q + BW'(1);
        if ((accept && last_word) || !gnt_req) begin
          state_d = IDLE;
          ptr_d   = wrap_add(gnt_q, 1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - scoreboard bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

  logic        wr_clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic        full;
  logic        wr_en;
  logic [7:0]  din;
  logic [1:0]  grant_id;
  logic        busy;

  always #5 wr_clk = ~wr_clk;

  fifo_wr_arbiter #(.NREQ(4), .DW(8), .MAX_BURST(4)) dut (
    .wr_clk(wr_clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
    .full(full), .wr_en(wr_en), .din(din), .grant_id(grant_id), .busy(busy)
  );

  typedef struct {
    int         cyc;
    logic [1:0] gid;
    logic [7:0] din;
    logic [3:0] ack;
  } wr_t;

  int         nvec = 0;
  int         nmis = 0;
  int         cyc = 0;
  int         wr_full = 0;
  logic [7:0] wmem [4][32];
  int         head [4];
  int         tail [4];
  logic [9:0] exp_q [$];
  wr_t        wlog [$];

  logic       o_wr;
  logic [7:0] o_din;
  logic [3:0] o_ack;
  logic [1:0] o_gid;
  logic       o_busy;

  // Requester model: each requester presents the head of its word list.
  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      req[i] = (head[i] < tail[i]);
      req_data[i*8 +: 8] = (head[i] < tail[i]) ? wmem[i][head[i]] : 8'h00;
    end
  endtask

  task automatic load(input int id, input int n, input logic [7:0] base);
    for (int j = 0; j < n; j++) begin
      wmem[id][tail[id]] = base + 8'(j);
      tail[id]++;
    end
    drive();
  endtask

  task automatic push_exp(input logic [1:0] id, input int n, input logic [7:0] base);
    for (int j = 0; j < n; j++) exp_q.push_back({id, base + 8'(j)});
  endtask

  // One clock: sample outputs mid-cycle, log writes, advance requesters on ack.
  task automatic cycle();
    @(negedge wr_clk);
    o_wr = wr_en; o_din = din; o_ack = ack; o_gid = grant_id; o_busy = busy;
    if (wr_en && full) wr_full++;
    if (wr_en) wlog.push_back('{cyc, grant_id, din, ack});
    @(posedge wr_clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (o_ack[i] && head[i] < tail[i]) head[i]++;
    cyc++;
    drive();
  endtask

  task automatic run_until(input int n, input int budget);
    for (int c = 0; c < budget && wlog.size() < n; c++) cycle();
  endtask

  task automatic clear_all();
    rst = 1'b1;
    full = 1'b0;
    for (int i = 0; i < 4; i++) begin head[i] = 0; tail[i] = 0; end
    exp_q.delete();
    wlog.delete();
    wr_full = 0;
    drive();
    @(posedge wr_clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_all();
    for (int i = 0; i < 4; i++) load(i, 8, 8'(16 * (i + 1)));
    push_exp(2'd0, 4, 8'h10);
    push_exp(2'd1, 2, 8'h20);
    run_until(6, 40);
    for (int k = 0; k < 6; k++) begin
      logic [9:0] e;
      e = exp_q.pop_front();
      nvec++;
      if (k >= wlog.size()) begin
        nmis++; $display("FAIL reset_pre[%0d] missing write, want %h", k, e);
      end else if ({wlog[k].gid, wlog[k].din} !== e) begin
        nmis++; $display("FAIL reset_pre[%0d] got %h want %h", k, {wlog[k].gid, wlog[k].din}, e);
      end
    end
    nvec++;
    if (wr_en !== 1'b1) begin nmis++; $display("FAIL reset_pre_wr got %b want 1", wr_en); end
    #2;
    rst = 1'b1;
    #1;
    nvec++; if (wr_en !== 1'b0) begin nmis++; $display("FAIL reset_wr_en got %b want 0", wr_en); end
    nvec++; if (ack !== 4'b0) begin nmis++; $display("FAIL reset_ack got %b want 0000", ack); end
    nvec++; if (din !== 8'h00) begin nmis++; $display("FAIL reset_din got %h want 00", din); end
    nvec++; if (busy !== 1'b0) begin nmis++; $display("FAIL reset_busy got %b want 0", busy); end
    nvec++; if (grant_id !== 2'd0) begin nmis++; $display("FAIL reset_grant_id got %0d want 0", grant_id); end
    @(posedge wr_clk);
    #1;
    rst = 1'b0;
    wlog.delete();
    exp_q.push_back({2'd0, 8'h14});
    run_until(1, 10);
    begin
      logic [9:0] e;
      e = exp_q.pop_front();
      nvec++;
      if (wlog.size() < 1) begin
        nmis++; $display("FAIL reset_first_grant timeout, want %h", e);
      end else if ({wlog[0].gid, wlog[0].din} !== e) begin
        nmis++; $display("FAIL reset_first_grant got %h want %h", {wlog[0].gid, wlog[0].din}, e);
      end
    end
  endtask

  task automatic test_single_burst();
    int dexp [5] = '{0, 1, 1, 1, 2};
    clear_all();
    load(0, 5, 8'h01);
    push_exp(2'd0, 5, 8'h01);
    run_until(5, 40);
    for (int k = 0; k < 5; k++) begin
      logic [9:0] e;
      e = exp_q.pop_front();
      nvec++;
      if (k >= wlog.size()) begin
        nmis++; $display("FAIL single_wr[%0d] missing, want %h", k, e);
      end else begin
        if ({wlog[k].gid, wlog[k].din} !== e) begin
          nmis++; $display("FAIL single_wr[%0d] got %h want %h", k, {wlog[k].gid, wlog[k].din}, e);
        end
        nvec++;
        if (wlog[k].ack !== 4'b0001) begin
          nmis++; $display("FAIL single_ack[%0d] got %b want 0001", k, wlog[k].ack);
        end
        if (k > 0) begin
          nvec++;
          if (wlog[k].cyc - wlog[k-1].cyc != dexp[k]) begin
            nmis++; $display("FAIL single_gap[%0d] got %0d want %0d", k, wlog[k].cyc - wlog[k-1].cyc, dexp[k]);
          end
        end
      end
    end
  endtask

  task automatic test_round_robin();
    clear_all();
    for (int i = 0; i < 4; i++) load(i, 4, 8'(16 * (i + 1)));
    load(0, 4, 8'h14);
    for (int i = 0; i < 4; i++) push_exp(2'(i), 4, 8'(16 * (i + 1)));
    push_exp(2'd0, 4, 8'h14);
    run_until(20, 80);
    for (int k = 0; k < 20; k++) begin
      logic [9:0] e;
      e = exp_q.pop_front();
      nvec++;
      if (k >= wlog.size()) begin
        nmis++; $display("FAIL rr_wr[%0d] missing, want %h", k, e);
      end else begin
        if ({wlog[k].gid, wlog[k].din} !== e) begin
          nmis++; $display("FAIL rr_wr[%0d] got %h want %h", k, {wlog[k].gid, wlog[k].din}, e);
        end
        nvec++;
        if (wlog[k].ack !== 4'(1 << e[9:8])) begin
          nmis++; $display("FAIL rr_ack[%0d] got %b want %b", k, wlog[k].ack, 4'(1 << e[9:8]));
        end
        if (k > 0) begin
          nvec++;
          if (wlog[k].cyc - wlog[k-1].cyc != ((k % 4 == 0) ? 2 : 1)) begin
            nmis++; $display("FAIL rr_gap[%0d] got %0d want %0d", k, wlog[k].cyc - wlog[k-1].cyc, (k % 4 == 0) ? 2 : 1);
          end
        end
      end
    end
  endtask

  task automatic test_full_stall();
    int dexp [4] = '{0, 1, 4, 1};
    clear_all();
    load(0, 4, 8'h51);
    push_exp(2'd0, 4, 8'h51);
    run_until(2, 20);
    full = 1'b1;
    for (int s = 0; s < 3; s++) begin
      cycle();
      nvec++;
      if (o_wr !== 1'b0 || o_ack !== 4'b0) begin
        nmis++; $display("FAIL stall_wr[%0d] got wr_en=%b ack=%b want 0/0000", s, o_wr, o_ack);
      end
      nvec++;
      if (o_busy !== 1'b1) begin nmis++; $display("FAIL stall_busy[%0d] got %b want 1", s, o_busy); end
    end
    full = 1'b0;
    run_until(4, 20);
    for (int c = 0; c < 6; c++) cycle();
    nvec++;
    if (wlog.size() != 4) begin nmis++; $display("FAIL stall_count got %0d want 4", wlog.size()); end
    nvec++;
    if (wr_full != 0) begin nmis++; $display("FAIL stall_wr_while_full got %0d want 0", wr_full); end
    for (int k = 0; k < 4; k++) begin
      logic [9:0] e;
      e = exp_q.pop_front();
      nvec++;
      if (k >= wlog.size()) begin
        nmis++; $display("FAIL stall_wr[%0d] missing, want %h", k, e);
      end else begin
        if ({wlog[k].gid, wlog[k].din} !== e) begin
          nmis++; $display("FAIL stall_data[%0d] got %h want %h", k, {wlog[k].gid, wlog[k].din}, e);
        end
        if (k > 0) begin
          nvec++;
          if (wlog[k].cyc - wlog[k-1].cyc != dexp[k]) begin
            nmis++; $display("FAIL stall_gap[%0d] got %0d want %0d", k, wlog[k].cyc - wlog[k-1].cyc, dexp[k]);
          end
        end
      end
    end
  endtask

  task automatic test_early_drop();
    int dexp [10] = '{0, 1, 3, 1, 1, 1, 2, 1, 1, 1};
    clear_all();
    load(1, 2, 8'h61);
    load(2, 4, 8'h71);
    load(3, 4, 8'h81);
    push_exp(2'd1, 2, 8'h61);
    push_exp(2'd2, 4, 8'h71);
    push_exp(2'd3, 4, 8'h81);
    run_until(10, 60);
    for (int k = 0; k < 10; k++) begin
      logic [9:0] e;
      e = exp_q.pop_front();
      nvec++;
      if (k >= wlog.size()) begin
        nmis++; $display("FAIL drop_wr[%0d] missing, want %h", k, e);
      end else begin
        if ({wlog[k].gid, wlog[k].din} !== e) begin
          nmis++; $display("FAIL drop_wr[%0d] got %h want %h", k, {wlog[k].gid, wlog[k].din}, e);
        end
        if (k > 0) begin
          nvec++;
          if (wlog[k].cyc - wlog[k-1].cyc != dexp[k]) begin
            nmis++; $display("FAIL drop_gap[%0d] got %0d want %0d", k, wlog[k].cyc - wlog[k-1].cyc, dexp[k]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_wrap();
    clear_all();
    load(3, 4, 8'h91);
    run_until(1, 10);
    nvec++;
    if (wlog.size() < 1 || {wlog[0].gid, wlog[0].din} !== {2'd3, 8'h91}) begin
      nmis++; $display("FAIL wrap_pre got %0d writes want first 391", wlog.size());
    end
    #2;
    rst = 1'b1;
    #1;
    nvec++;
    if ({wr_en, ack, din, busy, grant_id} !== 16'h0) begin
      nmis++; $display("FAIL wrap_reset_out got wr_en=%b ack=%b din=%h busy=%b gid=%0d want all 0",
                       wr_en, ack, din, busy, grant_id);
    end
    @(posedge wr_clk);
    #1;
    rst = 1'b0;
    wlog.delete();
    load(0, 5, 8'hA1);
    push_exp(2'd0, 4, 8'hA1);
    push_exp(2'd3, 3, 8'h92);
    push_exp(2'd0, 1, 8'hA5);
    run_until(8, 60);
    for (int k = 0; k < 8; k++) begin
      logic [9:0] e;
      e = exp_q.pop_front();
      nvec++;
      if (k >= wlog.size()) begin
        nmis++; $display("FAIL wrap_wr[%0d] missing, want %h", k, e);
      end else if ({wlog[k].gid, wlog[k].din} !== e) begin
        nmis++; $display("FAIL wrap_wr[%0d] got %h want %h", k, {wlog[k].gid, wlog[k].din}, e);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    full = 1'b0;
    req = '0;
    req_data = '0;
    test_reset();
    test_single_burst();
    test_round_robin();
    test_full_stall();
    test_early_drop();
    test_reset_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
